// File: rtl/gate_vector_checker.sv
// Applies the four input vectors 00,01,10,11 to a two-input gate under test,
// lets each one settle, samples z and counts mismatches against EXPECT_OP.
module gate_vector_checker #(
  parameter int SETTLE    = 4,
  parameter int EXPECT_OP = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       x,
  output logic       y,
  input  logic       z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] vec_idx,
  output logic [1:0] dbg_state
);

  // Handshake: start is a level request accepted only in IDLE (no ready is
  // returned; busy shows acceptance), done is a one-cycle completion strobe
  // and err_count/pass stay valid from done until the next accepted start.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       exp_z;
  logic       mismatch;
  logic [2:0] err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_SETTLE;
      S_SETTLE: if (cnt == CNT_LAST) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = (vec_idx == 2'd3) ? S_DONE : S_SETTLE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == S_SETTLE) || (state == S_SAMPLE);
    done      = (state == S_DONE);
    x         = busy & vec_idx[1];
    y         = busy & vec_idx[0];
    dbg_state = state;
  end

  always_comb begin
    case (EXPECT_OP)
      0:       exp_z = x | y;
      1:       exp_z = x & y;
      2:       exp_z = x ^ y;
      default: exp_z = ~(x | y);
    endcase
    mismatch = (z != exp_z);
    // saturating, although four vectors can never push it past 4
    err_nxt  = (mismatch && err_count != 3'd7) ? err_count + 3'd1 : err_count;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      vec_idx   <= '0;
      err_count <= '0;
      pass      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt       <= '0;
            vec_idx   <= '0;
            err_count <= '0;
            pass      <= 1'b0;
          end
        end
        S_SETTLE: cnt <= (cnt == CNT_LAST) ? 4'd0 : cnt + 4'd1;
        S_SAMPLE: begin
          err_count <= err_nxt;
          // 3 wraps to 0, so vec_idx is already 0 once the run is back in IDLE
          vec_idx   <= vec_idx + 2'd1;
          if (vec_idx == 2'd3) pass <= (err_nxt == 3'd0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Bench for gate_vector_checker: a NOR-expecting and an OR-expecting instance
// share one behavioural gate; done pulses are checked against a queue.
module tb_gate_vector_checker;

  localparam int SETTLE = 4;
  localparam int RUN_LEN = 4 * (SETTLE + 1);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  int         z_mode = 0;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  logic       x0, y0, z0, busy0, done0, pass0;
  logic [2:0] err0;
  logic [1:0] idx0, st0;
  logic       x3, y3, z3, busy3, done3, pass3;
  logic [2:0] err3;
  logic [1:0] idx3, st3;

  // entry = {done cycle, pass, err_count}
  logic [35:0] exp0_q[$];
  logic [35:0] exp3_q[$];

  // 0=OR 1=AND 2=XOR 3=NOR 4=stuck at 0
  function automatic logic gate(input int m, input logic a, input logic b);
    case (m)
      0:       return a | b;
      1:       return a & b;
      2:       return a ^ b;
      3:       return ~(a | b);
      default: return 1'b0;
    endcase
  endfunction

  assign z0 = gate(z_mode, x0, y0);
  assign z3 = gate(z_mode, x3, y3);

  gate_vector_checker #(.SETTLE(SETTLE), .EXPECT_OP(0)) u_or (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x0), .y(y0), .z(z0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .vec_idx(idx0), .dbg_state(st0)
  );

  gate_vector_checker #(.SETTLE(SETTLE), .EXPECT_OP(3)) u_nor (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x3), .y(y3), .z(z3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .vec_idx(idx3), .dbg_state(st3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitors: pop one expectation per done pulse
  always @(negedge clk) begin
    if (rst_n && done0) begin
      if (exp0_q.size() == 0) check("or_unexpected_done", 1, 0);
      else begin
        logic [35:0] e;
        e = exp0_q.pop_front();
        check("or_done_cycle", cyc, int'(e[35:4]));
        check("or_err_count", int'(err0), int'(e[2:0]));
        check("or_pass", int'(pass0), int'(e[3]));
      end
    end
    if (rst_n && done3) begin
      if (exp3_q.size() == 0) check("nor_unexpected_done", 1, 0);
      else begin
        logic [35:0] e;
        e = exp3_q.pop_front();
        check("nor_done_cycle", cyc, int'(e[35:4]));
        check("nor_err_count", int'(err3), int'(e[2:0]));
        check("nor_pass", int'(pass3), int'(e[3]));
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 4 * RUN_LEN && (exp0_q.size() != 0 || exp3_q.size() != 0); i++)
      @(negedge clk);
    if (exp0_q.size() != 0 || exp3_q.size() != 0) begin
      check("done_timeout", exp0_q.size() + exp3_q.size(), 0);
      exp0_q.delete();
      exp3_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic launch(input int mode, output int e);
    z_mode = mode;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    e = cyc;
    start = 1'b0;
  endtask

  task automatic do_run(input int mode, input logic [2:0] e0, input logic p0,
                        input logic [2:0] e3, input logic p3);
    int e;
    launch(mode, e);
    exp0_q.push_back({32'(e + RUN_LEN), p0, e0});
    exp3_q.push_back({32'(e + RUN_LEN), p3, e3});
    for (int k = 0; k < 4; k++) begin
      while (cyc < e + 5 * k + 2) @(negedge clk);
      check("vec_xy", int'({x0, y0}), k);
      check("vec_idx", int'(idx0), k);
      check("busy_in_run", int'(busy0), 1);
      if (k == 0) begin
        check("pass_cleared", int'(pass0), 0);
        check("err_cleared", int'(err3), 0);
      end
    end
    wait_idle();
    check("idle_xy", int'({x0, y0, x3, y3}), 0);
    check("idle_busy", int'({busy0, busy3}), 0);
  endtask

  initial begin
    int e;
    #2;
    check("rst_outputs", int'({x0, y0, busy0, done0, pass0, err0, idx0}), 0);
    check("rst_state", int'(st0), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    do_run(0, 3'd0, 1'b1, 3'd4, 1'b0);   // correct OR gate
    do_run(4, 3'd3, 1'b0, 3'd1, 1'b0);   // z stuck at 0
    do_run(1, 3'd2, 1'b0, 3'd2, 1'b0);   // AND gate in place of OR
    do_run(3, 3'd4, 1'b0, 3'd0, 1'b1);   // NOR gate

    repeat (6) @(negedge clk);
    check("hold_err_or", int'(err0), 4);
    check("hold_pass_or", int'(pass0), 0);
    check("hold_err_nor", int'(err3), 0);
    check("hold_pass_nor", int'(pass3), 1);

    // start held high: back-to-back runs every RUN_LEN+2 cycles
    z_mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    e = cyc;
    exp0_q.push_back({32'(e + RUN_LEN), 1'b1, 3'd0});
    exp0_q.push_back({32'(e + 2 * RUN_LEN + 2), 1'b1, 3'd0});
    exp3_q.push_back({32'(e + RUN_LEN), 1'b0, 3'd4});
    exp3_q.push_back({32'(e + 2 * RUN_LEN + 2), 1'b0, 3'd4});
    while (cyc < e + RUN_LEN + 2) @(negedge clk);
    check("restart_busy", int'(busy0), 1);
    start = 1'b0;
    wait_idle();

    // reset during SETTLE of vector 2 aborts silently
    launch(4, e);
    for (int i = 0; i < 4 * RUN_LEN && idx0 != 2'd2; i++) @(negedge clk);
    check("abort_reached_vec2", int'(idx0), 2);
    check("abort_in_settle", int'(st0), 1);
    check("abort_err_before", int'(err0), 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_outputs_or", int'({x0, y0, busy0, done0, pass0, err0, idx0}), 0);
    check("abort_outputs_nor", int'({x3, y3, busy3, done3, pass3, err3, idx3}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (RUN_LEN) @(negedge clk);
    check("abort_no_done_idle", int'(st0), 0);
    do_run(0, 3'd0, 1'b1, 3'd4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gate_vector_checker.md
GATE_VECTOR_CHECKER -- requirements
Module: gate_vector_checker

Interface
REQ-001 The block SHALL have parameter SETTLE, default 4, meaning cycles each vector is held before z is sampled (legal 1..15).
REQ-002 The block SHALL have parameter EXPECT_OP, default 0, meaning the expected gate function: 0=OR, 1=AND, 2=XOR, 3=NOR.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port start  input  1  run request, sampled only in IDLE.
REQ-006 The block SHALL have port x  output  1  gate-under-test input A.
REQ-007 The block SHALL have port y  output  1  gate-under-test input B.
REQ-008 The block SHALL have port z  input  1  gate-under-test output, synchronous to clk.
REQ-009 The block SHALL have port busy  output  1  high while a run is in progress.
REQ-010 The block SHALL have port done  output  1  one-cycle pulse at end of run.
REQ-011 The block SHALL have port pass  output  1  run result, 1 = zero mismatches.
REQ-012 The block SHALL have port err_count  output  3  number of mismatching vectors in last run (0..4).
REQ-013 The block SHALL have port vec_idx  output  2  index of vector currently applied.

Function
REQ-014 The FSM SHALL have states IDLE, SETTLE, SAMPLE, DONE.
REQ-015 In IDLE with start=1 at edge T, the FSM SHALL enter SETTLE; vec_idx=0, err_count=0, pass=0 from cycle T+1.
REQ-016 Applied vector SHALL be x=vec_idx[1], y=vec_idx[0], i.e. order 00, 01, 10, 11.
REQ-017 SETTLE SHALL last exactly SETTLE cycles (internal counter 0..SETTLE-1), then go to SAMPLE.
REQ-018 SAMPLE SHALL last one cycle; at its closing edge z SHALL be compared with EXPECT_OP(x,y) and err_count incremented on mismatch.
REQ-019 From SAMPLE with vec_idx<3, the FSM SHALL increment vec_idx and re-enter SETTLE; with vec_idx=3 it SHALL enter DONE.
REQ-020 Each vector SHALL be held SETTLE+1 cycles; done SHALL be high exactly in cycle T+1+4*(SETTLE+1) (T+21 for SETTLE=4).
REQ-021 DONE SHALL last one cycle with done=1, pass=(err_count==0 after last compare), then return to IDLE.
REQ-022 err_count and pass SHALL hold their values after DONE until the next accepted start.
REQ-023 busy SHALL be 1 in SETTLE and SAMPLE, 0 in IDLE and DONE.
REQ-024 x and y SHALL be 0 in IDLE and DONE; vec_idx SHALL hold 0 in IDLE.
REQ-025 start SHALL be ignored in SETTLE, SAMPLE and DONE; a start held high SHALL launch the next run from the first IDLE cycle.
REQ-026 err_count SHALL not wrap; max value 4 fits 3 bits.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE and x=0, y=0, busy=0, done=0, pass=0, err_count=0, vec_idx=0, settle counter=0.
REQ-028 Reset asserted mid-run SHALL abort the run with no done pulse; first start after release SHALL begin a clean run.

Verification
REQ-029 Correct OR gate (z=x|y), SETTLE=4, start at cycle 10 -> x/y show 00,01,10,11 each for 5 cycles, done in cycle 31, pass=1, err_count=0.
REQ-030 z stuck at 0, EXPECT_OP=0 -> err_count=3, pass=0.
REQ-031 z=x&y with EXPECT_OP=0 -> mismatches on vectors 01 and 10, err_count=2, pass=0.
REQ-032 z=~(x|y) with EXPECT_OP=0 -> err_count=4, pass=0; same gate with EXPECT_OP=3 -> err_count=0, pass=1.
REQ-033 start held high continuously -> runs back-to-back, one done pulse per 22 cycles (SETTLE=4), no restart while busy=1.
REQ-034 rst_n pulsed low during SETTLE of vec_idx=2 -> all outputs 0 asynchronously, no done; fresh start then yields correct result.
